// File: rtl/uart_rx_engine.sv
// -----------------------------------------------------------------------------
// uart_rx_engine
//
// Receive half of the UART serial link. RX is synchronised to clk, a falling
// edge starts a frame, and each bit is sampled near its middle using a 19-bit
// down-counter. Seven or eight data bits arrive LSB first, followed by an
// optional parity bit and one stop bit. When the stop bit has been sampled,
// the character and its status flags are loaded and RX_INTR pulses for one
// clock.
//
// Ports
//   clk      in   system clock (100 MHz)
//   rst      in   asynchronous active-low reset
//   RX       in   serial input, idle high
//   EIGHT    in   1 = 8 data bits, 0 = 7 data bits
//   PEN      in   1 = parity bit present
//   OHEL     in   parity sense: 1 = odd, 0 = even
//   BAUD     in   [3:0] baud select (bit-time lookup below)
//   clr      in   read acknowledge; clears RXRDY/PERR/FERR/OVF, holds DATA
//   DATA     out  [7:0] received character (bit7 = 0 in 7-bit mode)
//   RXRDY    out  character available
//   PERR     out  parity error on the last character
//   FERR     out  framing error (stop bit sampled low)
//   OVF      out  sticky: a character was overwritten before it was read
//   RX_INTR  out  one-cycle pulse per completed frame
// -----------------------------------------------------------------------------
module uart_rx_engine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic [3:0] BAUD,
    input  logic       clr,
    output logic [7:0] DATA,
    output logic       RXRDY,
    output logic       PERR,
    output logic       FERR,
    output logic       OVF,
    output logic       RX_INTR
);

    // A single-flop synchroniser is never acceptable, so clamp the depth.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // -------------------------------------------------------------------------
    // RX synchroniser. Reset value is all ones (line idle) so that leaving
    // reset never looks like a falling edge.
    // -------------------------------------------------------------------------
    logic [SYNC_N-1:0] sync_reg;
    logic              rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_N-2:0], RX};
        end
    end

    assign rx_s = sync_reg[SYNC_N-1];

    // -------------------------------------------------------------------------
    // Bit time in clocks for each BAUD code at 100 MHz. Unused codes fall
    // back to the 115200 setting.
    // -------------------------------------------------------------------------
    logic [18:0] k_sel;

    always_comb begin
        k_sel = 19'd868;
        case (BAUD)
            4'd0:    k_sel = 19'd333333;
            4'd1:    k_sel = 19'd83333;
            4'd2:    k_sel = 19'd41667;
            4'd3:    k_sel = 19'd20833;
            4'd4:    k_sel = 19'd10417;
            4'd5:    k_sel = 19'd5208;
            4'd6:    k_sel = 19'd2604;
            4'd7:    k_sel = 19'd1736;
            4'd8:    k_sel = 19'd868;
            4'd9:    k_sel = 19'd434;
            4'd10:   k_sel = 19'd217;
            4'd11:   k_sel = 19'd109;
            default: k_sel = 19'd868;
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame state. Configuration is captured when a start edge is seen so a
    // mid-frame change of EIGHT/PEN/OHEL/BAUD only affects the next frame.
    // -------------------------------------------------------------------------
    logic [2:0]  state_reg;
    logic [18:0] cnt_reg;
    logic [18:0] k_reg;
    logic        eight_reg;
    logic        pen_reg;
    logic        ohel_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_reg;
    logic        par_reg;    // running XOR of the data bits
    logic        perr_reg;   // parity verdict for the current frame

    logic tick;
    logic last_bit;
    logic frame_done;

    // The counter is loaded with N and the sample is taken on the cycle it
    // reads 1, giving N cycles between successive samples.
    assign tick       = (cnt_reg == 19'd1);
    assign last_bit   = (bit_reg == (eight_reg ? 3'd7 : 3'd6));
    assign frame_done = (state_reg == S_STOP) && tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            k_reg     <= '0;
            eight_reg <= 1'b0;
            pen_reg   <= 1'b0;
            ohel_reg  <= 1'b0;
            shift_reg <= '0;
            bit_reg   <= '0;
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_reg <= S_START;
                        cnt_reg   <= k_sel >> 1;
                        k_reg     <= k_sel;
                        eight_reg <= EIGHT;
                        pen_reg   <= PEN;
                        ohel_reg  <= OHEL;
                        bit_reg   <= '0;
                        par_reg   <= 1'b0;
                        perr_reg  <= 1'b0;
                    end
                end

                S_START: begin
                    if (tick) begin
                        cnt_reg <= k_reg;
                        // Line back high at mid start bit: a glitch, not a frame.
                        state_reg <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_reg <= cnt_reg - 19'd1;
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        cnt_reg   <= k_reg;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        par_reg   <= par_reg ^ rx_s;
                        bit_reg   <= bit_reg + 3'd1;
                        if (last_bit) begin
                            state_reg <= pen_reg ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 19'd1;
                    end
                end

                S_PARITY: begin
                    if (tick) begin
                        cnt_reg   <= k_reg;
                        // XOR of data, parity bit and sense is 1 on error.
                        perr_reg  <= par_reg ^ rx_s ^ ohel_reg;
                        state_reg <= S_STOP;
                    end else begin
                        cnt_reg <= cnt_reg - 19'd1;
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        // A low stop bit still ends the frame; if RX stays low
                        // IDLE picks it up as a new start on the next cycle.
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 19'd1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Character and status registers. Frame completion has priority over clr;
    // a coincident clr only changes the overflow decision.
    // -------------------------------------------------------------------------
    logic [7:0] data_next;

    // In 7-bit mode only seven shifts happen, so the character sits one
    // position high in the shift register.
    assign data_next = eight_reg ? shift_reg : {1'b0, shift_reg[7:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DATA    <= '0;
            RXRDY   <= 1'b0;
            PERR    <= 1'b0;
            FERR    <= 1'b0;
            OVF     <= 1'b0;
            RX_INTR <= 1'b0;
        end else if (frame_done) begin
            DATA    <= data_next;
            RXRDY   <= 1'b1;
            PERR    <= pen_reg & perr_reg;
            FERR    <= ~rx_s;
            OVF     <= clr ? 1'b0 : (OVF | RXRDY);
            RX_INTR <= 1'b1;
        end else begin
            RX_INTR <= 1'b0;
            if (clr) begin
                RXRDY <= 1'b0;
                PERR  <= 1'b0;
                FERR  <= 1'b0;
                OVF   <= 1'b0;
            end
        end
    end

endmodule
